// File: rtl/piso_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : piso_rr_scheduler
//  Purpose  : Round-robin arbiter feeding one shared MSB-first PISO shifter.
//  Revision : 1.0  initial release
// ============================================================================
module piso_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      so,
    output logic                      so_valid,
    output logic                      so_first,
    output logic                      so_last,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_SW = c_IW + 1;
    localparam int c_CW = $clog2(WIDTH);
    localparam int c_GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(WIDTH - 1);
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [c_IW-1:0] c_PTR_MAX  = c_IW'(NREQ - 1);
    localparam logic [c_SW-1:0] c_NREQ_S   = c_SW'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_shift;
    logic [WIDTH-1:0]    w_shift_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_nxt;
    logic [c_GW-1:0]     r_gap;
    logic [c_GW-1:0]     w_gap_nxt;
    logic [c_IW-1:0]     r_ptr;
    logic [c_IW-1:0]     w_ptr_nxt;
    logic [c_IW-1:0]     r_gid;
    logic [c_IW-1:0]     w_gid_nxt;

    logic                w_found;
    logic [c_IW-1:0]     w_win;
    logic [c_SW-1:0]     w_sum;
    logic [WIDTH-1:0]    w_word;

    // Rotating search: first valid requester at or after the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_SW'(k);
            if (w_sum >= c_NREQ_S) begin
                w_sum = w_sum - c_NREQ_S;
            end
            if (!w_found && req_valid[w_sum[c_IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_IW-1:0];
            end
        end
    end

    assign w_word    = req_data[w_win*WIDTH +: WIDTH];
    assign req_ready = (r_state == S_IDLE && !rst && w_found)
                     ? (NREQ'(1) << w_win) : '0;
    assign grant_id  = r_gid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_ptr   <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gid   <= w_gid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_ptr_nxt   = r_ptr;
        w_gid_nxt   = r_gid;
        so          = 1'b0;
        so_valid    = 1'b0;
        so_first    = 1'b0;
        so_last     = 1'b0;
        busy        = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_shift_nxt = w_word;
                    w_cnt_nxt   = c_CNT_MAX;
                    w_gid_nxt   = w_win;
                    w_ptr_nxt   = (w_win == c_PTR_MAX) ? '0 : (w_win + 1'b1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                so          = r_shift[WIDTH-1];
                so_valid    = 1'b1;
                so_first    = (r_cnt == c_CNT_MAX);
                so_last     = (r_cnt == '0);
                w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                if (r_cnt == '0) begin
                    if (GAP > 0) begin
                        w_gap_nxt   = c_GAP_LOAD;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                // Counter was loaded with GAP-1, so this state lasts GAP cycles.
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
